sd_xfer_scheduler: RTL and testbench

Arbitrates SD block-transfer requests from two requesters (A, B) and programs the SD host register file for the winner. Each granted descriptor is written out as the fixed six-write register program: block size, block count, transfer mode, argument low, argument high, then command. It then waits for the host's transfer-complete indication before accepting the next request. The block sits between the system-side requesters and the `sd_host` register write port, i.e. `reg_address`, `reg_wr_data`, `reg_wr_en` and `req`.

---
 rtl/sd_xfer_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_sd_xfer_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_xfer_scheduler.sv
// sd_xfer_scheduler: round-robin arbiter for two SD transfer requesters that writes the
// six-register command program into sd_host. Define SD_SCHED_TIMEOUT_EN to add the WAIT timeout.
module sd_xfer_scheduler #(
    parameter int          TIMEOUT_W = 16,
    parameter int unsigned TIMEOUT   = 32'h0000_FFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [70:0] desc_a,
    input  logic [70:0] desc_b,
    input  logic        xfer_done,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [31:0] reg_address,
    output logic [31:0] reg_wr_data,
    output logic        reg_wr_en,
    output logic        req,
    output logic        busy,
    output logic        done_a,
    output logic        done_b,
    output logic        err_desc,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        owner_b_q, owner_b_d;
    logic        last_b_q, last_b_d;
    logic        reject_q, reject_d;
    logic [70:0] desc_q, desc_d;

    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_en_q, wr_en_d;
    logic        busy_q, busy_d;
    logic        done_a_q, done_a_d;
    logic        done_b_q, done_b_d;
    logic        err_desc_q, err_desc_d;

    logic        timeout_hit;
    logic        pick_b;

    // DONE arbitrates like IDLE so a pending request is granted the cycle after the done pulse.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        owner_b_d  = owner_b_q;
        last_b_d   = last_b_q;
        reject_d   = reject_q;
        desc_d     = desc_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        err_desc_d = 1'b0;
        pick_b     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req_a || req_b) begin
                    pick_b    = req_b && (!req_a || !last_b_q);
                    state_d   = PROG;
                    step_d    = 3'd0;
                    owner_b_d = pick_b;
                    last_b_d  = pick_b;
                    desc_d    = pick_b ? desc_b : desc_a;
                    reject_d  = (desc_d[31:16] == 16'd0) || (desc_d[15:0] == 16'd0);
                    gnt_a_d   = !pick_b;
                    gnt_b_d   = pick_b;
                end
            end
            PROG: begin
                if (reject_q) begin
                    state_d    = DONE;
                    err_desc_d = 1'b1;
                end else if (step_q == 3'd5) begin
                    state_d = WAIT;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            WAIT: begin
                if (xfer_done || timeout_hit) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register-port word for the step about to be presented; a rejected grant writes nothing.
    always_comb begin
        addr_d   = 32'd0;
        data_d   = 32'd0;
        wr_en_d  = (state_d == PROG) && !reject_d;
        busy_d   = (state_d != IDLE);
        done_a_d = (state_d == DONE) && !owner_b_d;
        done_b_d = (state_d == DONE) && owner_b_d;
        if (wr_en_d) begin
            case (step_d)
                3'd0: begin
                    addr_d = 32'h0000_0004;
                    data_d = {16'd0, desc_d[15:0]};
                end
                3'd1: begin
                    addr_d = 32'h0000_0006;
                    data_d = {16'd0, desc_d[31:16]};
                end
                3'd2: begin
                    addr_d = 32'h0000_000C;
                    data_d = {26'd0, (desc_d[31:16] > 16'd1), desc_d[70], 2'b00, 2'b11};
                end
                3'd3: begin
                    addr_d = 32'h0000_0008;
                    data_d = {16'd0, desc_d[47:32]};
                end
                3'd4: begin
                    addr_d = 32'h0000_000A;
                    data_d = {16'd0, desc_d[63:48]};
                end
                3'd5: begin
                    addr_d = 32'h0000_000E;
                    data_d = {18'd0, desc_d[69:64], 8'h33};
                end
                default: begin
                    addr_d = 32'd0;
                    data_d = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            step_q     <= 3'd0;
            owner_b_q  <= 1'b0;
            last_b_q   <= 1'b1;
            reject_q   <= 1'b0;
            desc_q     <= 71'd0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_a_q   <= 1'b0;
            done_b_q   <= 1'b0;
            err_desc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            owner_b_q  <= owner_b_d;
            last_b_q   <= last_b_d;
            reject_q   <= reject_d;
            desc_q     <= desc_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_a_q   <= done_a_d;
            done_b_q   <= done_b_d;
            err_desc_q <= err_desc_d;
        end
    end

`ifdef SD_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 err_tmo_q, err_tmo_d;

    // The count equals the number of WAIT cycles already spent; xfer_done beats expiry.
    assign timeout_hit = (tmo_cnt_q == TIMEOUT_W'(TIMEOUT - 32'd1));

    always_comb begin
        tmo_cnt_d = (state_q == WAIT) ? tmo_cnt_q + 1'b1 : '0;
        err_tmo_d = (state_q == WAIT) && !xfer_done && timeout_hit;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign err_timeout = err_tmo_q;
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_cfg  = ^{TIMEOUT_W, TIMEOUT};
`endif

    assign gnt_a       = gnt_a_q;
    assign gnt_b       = gnt_b_q;
    assign reg_address = addr_q;
    assign reg_wr_data = data_q;
    assign reg_wr_en   = wr_en_q;
    assign req         = wr_en_q;
    assign busy        = busy_q;
    assign done_a      = done_a_q;
    assign done_b      = done_b_q;
    assign err_desc    = err_desc_q;

endmodule

// File: tb/tb_sd_xfer_scheduler.sv
// Testbench for sd_xfer_scheduler: directed and random transfers checked against a
// descriptor-level reference model of arbitration, register program and completion timing.
module tb_sd_xfer_scheduler;

    localparam int TMO = 16;
`ifdef SD_SCHED_TIMEOUT_EN
    localparam int LONG_WAIT = TMO;
`else
    localparam int LONG_WAIT = 20;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_a, req_b;
    logic [70:0] desc_a, desc_b;
    logic        xfer_done;
    logic        gnt_a, gnt_b;
    logic [31:0] reg_address, reg_wr_data;
    logic        reg_wr_en, req, busy, done_a, done_b, err_desc, err_timeout;

    int tests_run    = 0;
    int tests_failed = 0;
    bit model_last_b = 1'b1;

    sd_xfer_scheduler #(.TIMEOUT_W(16), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_a(req_a), .req_b(req_b),
        .desc_a(desc_a), .desc_b(desc_b),
        .xfer_done(xfer_done),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .reg_address(reg_address), .reg_wr_data(reg_wr_data),
        .reg_wr_en(reg_wr_en), .req(req), .busy(busy),
        .done_a(done_a), .done_b(done_b),
        .err_desc(err_desc), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check_flags_quiet(input string tag);
        check(tag, {23'd0, gnt_a, gnt_b, reg_wr_en, req, busy, done_a, done_b, err_desc, err_timeout}, 32'd0);
    endtask

    function automatic logic [70:0] make_desc(input bit rd, input int unsigned cmd, input int unsigned arg,
                                              input int unsigned cnt, input int unsigned size);
        return {rd, 6'(cmd), 32'(arg), 16'(cnt), 16'(size)};
    endfunction

    function automatic int unsigned rand_len();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 0;
        if (sel <= 2) return 1;
        return $urandom_range(2, 65535);
    endfunction

    function automatic logic [70:0] rand_desc();
        return make_desc(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom,
                         rand_len(), rand_len());
    endfunction

    // One full transfer starting at the negedge before the granting edge; ends at the done-cycle negedge.
    task automatic do_transfer(input int wait_cycles, input bit drop, input bit glitch, input bit expect_tmo);
        bit          w;
        logic [70:0] d;
        int unsigned size, cnt, arg, cmd;
        bit          rd;
        int unsigned exp_addr[6];
        int unsigned exp_data[6];

        w    = (req_a && req_b) ? !model_last_b : req_b;
        d    = w ? desc_b : desc_a;
        size = d[15:0];
        cnt  = d[31:16];
        arg  = d[63:32];
        cmd  = d[69:64];
        rd   = d[70];

        tick();
        check("gnt_a", gnt_a, !w);
        check("gnt_b", gnt_b, w);
        check("busy_at_grant", busy, 1);
        model_last_b = w;
        if (drop) begin
            if (w) req_b = 1'b0;
            else   req_a = 1'b0;
        end

        if (cnt == 0 || size == 0) begin
            check("reject_no_write", reg_wr_en, 0);
            tick();
            check("reject_done_a", done_a, !w);
            check("reject_done_b", done_b, w);
            check("reject_err_desc", err_desc, 1);
            check("reject_no_write2", {gnt_a, gnt_b, reg_wr_en, err_timeout}, 0);
            return;
        end

        exp_addr = '{32'h4, 32'h6, 32'hC, 32'h8, 32'hA, 32'hE};
        exp_data[0] = size;
        exp_data[1] = cnt;
        exp_data[2] = 3 + (rd ? 16 : 0) + (cnt > 1 ? 32 : 0);
        exp_data[3] = arg % 65536;
        exp_data[4] = arg / 65536;
        exp_data[5] = cmd * 256 + 'h33;

        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                tick();
                check("gnt_in_prog", {gnt_a, gnt_b}, 0);
            end
            check("wr_en", {reg_wr_en, req}, 2'b11);
            check($sformatf("addr_step%0d", k), reg_address, exp_addr[k]);
            check($sformatf("data_step%0d", k), reg_wr_data, exp_data[k]);
            if (glitch) xfer_done = (k == 2);
        end
        xfer_done = 1'b0;

        if (expect_tmo) begin
            for (int i = 0; i < TMO; i++) begin
                tick();
                check("tmo_wait", {reg_wr_en, done_a, done_b, busy}, 4'b0001);
            end
            tick();
            check("tmo_done_a", done_a, !w);
            check("tmo_done_b", done_b, w);
            check("tmo_err_timeout", err_timeout, 1);
            check("tmo_err_desc", err_desc, 0);
            return;
        end

        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            check("wait_state", {reg_wr_en, done_a, done_b, busy}, 4'b0001);
        end
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        check("done_a", done_a, !w);
        check("done_b", done_b, w);
        check("done_flags", {reg_wr_en, err_desc, err_timeout, busy}, 4'b0001);
    endtask

    initial begin
        RESET     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        desc_a    = '0;
        desc_b    = '0;
        xfer_done = 1'b0;
        #12;
        check_flags_quiet("reset_flags");
        check("reset_addr", reg_address, 0);
        check("reset_data", reg_wr_data, 0);
        tick();
        RESET = 1'b1;
        tick();
        check_flags_quiet("idle_after_reset");

        $display("[TB] single write from A");
        desc_a = make_desc(0, 'h19, 32'h7654_3210, 10, 64);
        req_a  = 1'b1;
        do_transfer(LONG_WAIT, 1, 0, 0);
        tick();
        check_flags_quiet("idle_after_write");

        $display("[TB] read from B with xfer_done during PROG");
        desc_b = make_desc(1, 'h12, 32'h8310_2140, 10, 64);
        req_b  = 1'b1;
        do_transfer(5, 1, 1, 0);
        tick();
        check_flags_quiet("idle_after_read");

        $display("[TB] contention");
        desc_a = make_desc(0, 'h18, 32'h0000_1000, 4, 512);
        desc_b = make_desc(1, 'h11, 32'h0000_2000, 1, 512);
        req_a  = 1'b1;
        req_b  = 1'b1;
        for (int t = 0; t < 3; t++) do_transfer(3, 0, 0, 0);
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        check_flags_quiet("idle_after_contention");

        $display("[TB] rejects");
        desc_a = make_desc(0, 'h19, 32'h1, 0, 64);
        req_a  = 1'b1;
        do_transfer(1, 1, 0, 0);
        tick();
        check_flags_quiet("idle_after_reject_a");
        desc_b = make_desc(1, 'h12, 32'h2, 3, 0);
        req_b  = 1'b1;
        do_transfer(1, 1, 0, 0);
        tick();
        check_flags_quiet("idle_after_reject_b");

        $display("[TB] single block write");
        desc_a = make_desc(0, 'h18, 32'hDEAD_BEEF, 1, 512);
        req_a  = 1'b1;
        do_transfer(2, 1, 0, 0);
        tick();
        check_flags_quiet("idle_after_single");

`ifdef SD_SCHED_TIMEOUT_EN
        $display("[TB] timeout");
        desc_a = make_desc(0, 'h19, 32'h1234_5678, 8, 64);
        req_a  = 1'b1;
        do_transfer(0, 1, 0, 1);
        tick();
        check_flags_quiet("idle_after_timeout");
        req_a = 1'b1;
        do_transfer(TMO, 1, 0, 0);
        tick();
        check_flags_quiet("idle_after_expiry_race");
`endif

        $display("[TB] reset during PROG");
        desc_a = make_desc(0, 'h19, 32'hAAAA_5555, 2, 64);
        desc_b = make_desc(1, 'h12, 32'h5555_AAAA, 2, 128);
        req_a  = 1'b1;
        tick();
        check("rst_gnt_a", gnt_a, 1);
        model_last_b = 1'b0;
        req_a = 1'b0;
        req_b = 1'b1;
        tick();
        tick();
        tick();
        check("rst_step3_addr", reg_address, 32'h8);
        RESET = 1'b0;
        #1;
        check_flags_quiet("rst_async_flags");
        check("rst_async_addr", reg_address, 0);
        check("rst_async_data", reg_wr_data, 0);
        tick();
        check_flags_quiet("rst_held_flags");
        RESET = 1'b1;
        model_last_b = 1'b1;
        do_transfer(3, 1, 0, 0);
        tick();
        check_flags_quiet("idle_after_reset_xfer");

        $display("[TB] random transfers");
        for (int n = 0; n < 14; n++) begin
            int pat;
            if ($urandom_range(0, 2) == 0) begin
                req_a = 1'b0;
                req_b = 1'b0;
                tick();
                check_flags_quiet("rand_idle");
            end
            pat    = $urandom_range(1, 3);
            req_a  = pat[0];
            req_b  = pat[1];
            desc_a = rand_desc();
            desc_b = rand_desc();
            do_transfer($urandom_range(1, TMO), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        check_flags_quiet("final_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
